spi_ram_arbiter: RTL
====================

# spi_ram_arbiter

Two-requester arbiter that shares the single-port 256x8 RAM between the SPI slave command path and a second local requester. Both requesters use the same 10-bit command word as the SPI slave: bits [9:8] are the opcode (00 write-addr, 01 write-data, 10 read-addr, 11 read-data) and bits [7:0] carry the address or data. The RAM holds its address registers internally, so a whole two-word transaction must not interleave with the other requester's. The arbiter therefore locks the RAM to one owner per transaction, forwards words as single-cycle `rx_valid` pulses, routes `tx_valid`/`dout` back to the owner, and recovers from stalled or malformed sequences.

## Interface
- ADDR_SIZE, 8, width of the address/data field; command width is ADDR_SIZE+2.
- LOCK_TIMEOUT, 255, idle cycles allowed between the address word and the data word before the lock is dropped.
- RD_TIMEOUT, 15, cycles allowed from the read-data issue to RAM `tx_valid`.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_valid / r1_valid  in  1  requester N presents a command word.
- r0_data / r1_data  in  ADDR_SIZE+2  command word.
- r0_ready / r1_ready  out  1  word accepted on an edge where valid&ready; combinational from state.
- r0_rsp_valid / r1_rsp_valid  out  1  one-cycle read-response strobe.
- r0_rsp_data / r1_rsp_data  out  ADDR_SIZE  read data; holds its last value.
- ram_din  out  ADDR_SIZE+2  word to the RAM.
- ram_rx_valid  out  1  one-cycle write strobe to the RAM.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  RAM read-data valid.
- owner  out  1  current/last granted requester.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle protocol/timeout error pulse.

## Operation
- States:
  - IDLE.
  - LOCK_W: write address issued, waiting for write-data.
  - LOCK_R: read address issued, waiting for read-data.
  - WAIT_RD: read-data issued, waiting for `ram_tx_valid`.
- Arbitration in IDLE:
  - Round-robin. If both requesters are valid, the one that is not `last` is ready. Otherwise the single valid requester is ready.
  - `last` updates to the accepted requester on every accept in IDLE.
- Ready in other states:
  - Only the owner is ready, in LOCK_W and LOCK_R.
  - Nobody is ready in WAIT_RD.
- IDLE accepts:
  - 00 → forward, go to LOCK_W.
  - 10 → forward, go to LOCK_R.
  - 01 or 11 → drop the word (no RAM strobe), pulse `err`, stay in IDLE.
- LOCK_W accepts:
  - 01 → forward, go to IDLE.
  - 00 → forward (re-address), stay in LOCK_W, restart the timeout.
  - 10 or 11 → drop, pulse `err`, stay in LOCK_W.
- LOCK_R accepts:
  - 11 → forward, go to WAIT_RD.
  - 10 → forward, stay in LOCK_R, restart the timeout.
  - 00 or 01 → drop, pulse `err`, stay in LOCK_R.
- WAIT_RD:
  - On `ram_tx_valid`: register `ram_dout` into the owner's `rsp_data`, pulse that requester's `rsp_valid`, go to IDLE.
  - `ram_tx_valid` seen in any other state is ignored. No response is generated and no error is raised.
- Timeouts: use a single 8-bit counter, cleared on each state entry and on every accept.
  - In LOCK_W/LOCK_R, count reaching LOCK_TIMEOUT → IDLE and pulse `err`.
  - In WAIT_RD, count reaching RD_TIMEOUT → IDLE, pulse `err`, no response.
- Reset values: state IDLE, `last`=1 (requester 0 wins the first tie), `owner`=0, all strobes 0, `ram_din`=0, `rsp_data`=0, counter 0.
- Reset asserted mid-transaction aborts with no RAM strobe and no response.

## Timing
- Word accepted at edge k → `ram_din` = word and `ram_rx_valid` = 1 for exactly cycle k+1.
- At most one `ram_rx_valid` per cycle. Words reach the RAM in acceptance order.
- Read: 11 accepted at edge k, `ram_rx_valid` in k+1, RAM `tx_valid` in k+2, `rN_rsp_valid` in k+3.
- The state returns to IDLE at the edge that raises `rsp_valid`. A new word may be accepted during the `rsp_valid` cycle.
- Write completes with 01 accepted at edge k. IDLE is entered at edge k, so the next grant can be accepted at edge k+1.
- `err` goes high in the cycle after the offending accept or timeout, for one cycle.
- Timeout fires on the edge where the counter equals the limit, which is LIMIT cycles after the last clear.

## Test plan
- Write then read, requester 0 only: send 0x0_A5, then 0x1_3C (opcode 01, data 0x3C), then 0x2_A5, then 0x3_00 → `ram_rx_valid` pulses carry the same words one cycle later; `r0_rsp_valid` 3 cycles after the 11 accept with `r0_rsp_data`=0x3C; `err` stays 0.
- Contention: both requesters valid in IDLE after reset → requester 0 granted; r1 stays not-ready until r0 completes its 01; the next tie goes to r1.
- Protocol error: r1 sends 0x1_55 in IDLE → no `ram_rx_valid`, `err` pulses once, state stays IDLE.
- Lock timeout: r0 sends 0x0_10, then idles 255 cycles → `err` pulse, `busy` drops, a pending r1 request is then granted.
- Read timeout: RAM model withholds `tx_valid` after a 11 → after 15 cycles `err` pulses, no `rsp_valid`, state IDLE.
- Reset in WAIT_RD: assert `rst_n` low mid-read → all outputs 0 immediately; the late `ram_tx_valid` after reset produces no response.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Two-requester lock arbiter in front of the single-port SPI command RAM.
// Grants one owner per address/data transaction and routes read responses back.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE    = 8,
  parameter int LOCK_TIMEOUT = 255,
  parameter int RD_TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r0_valid,
  input  logic [ADDR_SIZE+1:0] r0_data,
  output logic                 r0_ready,
  output logic                 r0_rsp_valid,
  output logic [ADDR_SIZE-1:0] r0_rsp_data,
  input  logic                 r1_valid,
  input  logic [ADDR_SIZE+1:0] r1_data,
  output logic                 r1_ready,
  output logic                 r1_rsp_valid,
  output logic [ADDR_SIZE-1:0] r1_rsp_data,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 owner,
  output logic                 busy,
  output logic                 err
);

  // The counter reads LIMIT-1 on the edge that completes LIMIT cycles since its clear.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_TIMEOUT - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOCK_W, LOCK_R, WAIT_RD} state_t;

  state_t               state, state_nx;
  logic                 last;
  logic [7:0]           cnt;
  logic                 accept, acc_sel;
  logic [ADDR_SIZE+1:0] word;
  logic [1:0]           op;
  logic                 fwd, err_nx, rsp_nx;

  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (r0_valid && r1_valid) begin
          r0_ready = last;
          r1_ready = !last;
        end else begin
          r0_ready = r0_valid;
          r1_ready = r1_valid;
        end
      end
      LOCK_W, LOCK_R: begin
        r0_ready = !owner;
        r1_ready = owner;
      end
      default: ;
    endcase
  end

  assign acc_sel = r1_valid && r1_ready;
  assign accept  = (r0_valid && r0_ready) || acc_sel;
  assign word    = acc_sel ? r1_data : r0_data;
  assign op      = word[ADDR_SIZE+1:ADDR_SIZE];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    fwd      = 1'b0;
    err_nx   = 1'b0;
    rsp_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            2'b00:   begin fwd = 1'b1; state_nx = LOCK_W; end
            2'b10:   begin fwd = 1'b1; state_nx = LOCK_R; end
            default: err_nx = 1'b1;
          endcase
        end
      end
      LOCK_W: begin
        if (accept) begin
          case (op)
            2'b01:   begin fwd = 1'b1; state_nx = IDLE; end
            2'b00:   fwd = 1'b1;
            default: err_nx = 1'b1;
          endcase
        end else if (cnt == LOCK_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      LOCK_R: begin
        if (accept) begin
          case (op)
            2'b11:   begin fwd = 1'b1; state_nx = WAIT_RD; end
            2'b10:   fwd = 1'b1;
            default: err_nx = 1'b1;
          endcase
        end else if (cnt == LOCK_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_RD: begin
        if (ram_tx_valid) begin
          rsp_nx   = 1'b1;
          state_nx = IDLE;
        end else if (cnt == RD_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      cnt          <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      err          <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rsp_data  <= '0;
      r1_rsp_data  <= '0;
    end else begin
      state        <= state_nx;
      ram_rx_valid <= fwd;
      err          <= err_nx;
      r0_rsp_valid <= rsp_nx && !owner;
      r1_rsp_valid <= rsp_nx && owner;
      if (fwd) ram_din <= word;
      if (rsp_nx) begin
        if (owner) r1_rsp_data <= ram_dout;
        else       r0_rsp_data <= ram_dout;
      end
      if (state == IDLE && accept) begin
        last  <= acc_sel;
        owner <= acc_sel;
      end
      if (state == IDLE || accept || state_nx != state) cnt <= '0;
      else                                              cnt <= cnt + 8'd1;
    end
  end

endmodule
